common_sync_debounce: RTL and testbench



---
 rtl/common_sync_debounce.sv | 166 ++++++++++++++++
 tb/tb_common_sync_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/common_sync_debounce.sv
// Glitch filter for an already-synchronized slow input: a new level is accepted only after
// FILTER_CYCLES consecutive samples, with rise/fall pulses and a saturating rise-event counter.
//
// state      | meaning
// -----------+-------------------------------------------------
// STABLE_L   | level_o = 0, input agrees with filtered level
// CHECK_H    | level_o = 0, counting consecutive high samples
// STABLE_H   | level_o = 1, input agrees with filtered level
// CHECK_L    | level_o = 1, counting consecutive low samples
module common_sync_debounce #(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned EVT_W         = 8,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             data_i,
    input  logic             enable_i,
    input  logic             evt_clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [EVT_W-1:0] evt_cnt_o,
    output logic             evt_ovf_o
);

    localparam logic [1:0] ST_STABLE_L = 2'd0;
    localparam logic [1:0] ST_CHECK_H  = 2'd1;
    localparam logic [1:0] ST_STABLE_H = 2'd2;
    localparam logic [1:0] ST_CHECK_L  = 2'd3;

    localparam logic [1:0]       LP_RESET_ST = RESET_LEVEL ? ST_STABLE_H : ST_STABLE_L;
    localparam logic [CNT_W-1:0] LP_CNT_TERM = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [EVT_W-1:0] LP_EVT_MAX  = '1;
    localparam logic             LP_SINGLE   = (FILTER_CYCLES == 1);

    // The stability counter must hold FILTER_CYCLES-1 without wrapping.
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_filter
        $error("common_sync_debounce: FILTER_CYCLES out of range for CNT_W");
    end

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [EVT_W-1:0] r_evt_cnt;
    logic             r_evt_ovf;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_level_nxt;
    logic [EVT_W-1:0] w_evt_base;
    logic             w_ovf_base;
    logic [EVT_W-1:0] w_evt_nxt;
    logic             w_ovf_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        if (!enable_i) begin
            w_state_nxt = r_level ? ST_STABLE_H : ST_STABLE_L;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_STABLE_L: begin
                    if (data_i && LP_SINGLE) begin
                        w_state_nxt = ST_STABLE_H;
                        w_rise      = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (data_i) begin
                        w_state_nxt = ST_CHECK_H;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                ST_CHECK_H: begin
                    if (!data_i) begin
                        w_state_nxt = ST_STABLE_L;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LP_CNT_TERM) begin
                        w_state_nxt = ST_STABLE_H;
                        w_rise      = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_STABLE_H: begin
                    if (!data_i && LP_SINGLE) begin
                        w_state_nxt = ST_STABLE_L;
                        w_fall      = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (!data_i) begin
                        w_state_nxt = ST_CHECK_L;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    if (data_i) begin
                        w_state_nxt = ST_STABLE_H;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LP_CNT_TERM) begin
                        w_state_nxt = ST_STABLE_L;
                        w_fall      = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_level_nxt = w_rise ? 1'b1 : (w_fall ? 1'b0 : r_level);

    // Clear is applied before the increment so a coincident rise is still counted.
    always_comb begin
        w_evt_base = evt_clr_i ? '0 : r_evt_cnt;
        w_ovf_base = evt_clr_i ? 1'b0 : r_evt_ovf;
        w_evt_nxt  = w_evt_base;
        w_ovf_nxt  = w_ovf_base;
        if (w_rise) begin
            if (w_evt_base == LP_EVT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_evt_nxt = w_evt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= LP_RESET_ST;
            r_cnt     <= '0;
            r_level   <= RESET_LEVEL;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_evt_cnt <= '0;
            r_evt_ovf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_rise    <= w_rise;
            r_fall    <= w_fall;
            r_evt_cnt <= w_evt_nxt;
            r_evt_ovf <= w_ovf_nxt;
        end
    end

    assign level_o   = r_level;
    assign rise_o    = r_rise;
    assign fall_o    = r_fall;
    assign evt_cnt_o = r_evt_cnt;
    assign evt_ovf_o = r_evt_ovf;

endmodule

// File: tb/tb_common_sync_debounce.sv
// Bench for common_sync_debounce: three parameterisations run against a run-length reference
// model, with directed latency/glitch/event checks and a randomized lockstep phase.
module tb_common_sync_debounce;

    logic       clk = 1'b0;
    logic [2:0] rst, data, en, clr;
    logic [2:0] level, rise, fall, ovf;
    logic [7:0] evt0, evt1;
    logic [1:0] evt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    common_sync_debounce u_dut0 (
        .clk_i(clk), .reset_i(rst[0]), .data_i(data[0]), .enable_i(en[0]), .evt_clr_i(clr[0]),
        .level_o(level[0]), .rise_o(rise[0]), .fall_o(fall[0]), .evt_cnt_o(evt0), .evt_ovf_o(ovf[0]));

    common_sync_debounce #(.FILTER_CYCLES(1), .RESET_LEVEL(1'b1)) u_dut1 (
        .clk_i(clk), .reset_i(rst[1]), .data_i(data[1]), .enable_i(en[1]), .evt_clr_i(clr[1]),
        .level_o(level[1]), .rise_o(rise[1]), .fall_o(fall[1]), .evt_cnt_o(evt1), .evt_ovf_o(ovf[1]));

    common_sync_debounce #(.FILTER_CYCLES(3), .CNT_W(2), .EVT_W(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst[2]), .data_i(data[2]), .enable_i(en[2]), .evt_clr_i(clr[2]),
        .level_o(level[2]), .rise_o(rise[2]), .fall_o(fall[2]), .evt_cnt_o(evt2), .evt_ovf_o(ovf[2]));

    // Reference model: level flips once FILTER_CYCLES enabled samples in a row disagree with it.
    int   fc[3]   = '{16, 1, 3};
    int   emax[3] = '{255, 255, 3};
    logic rl[3]   = '{1'b0, 1'b1, 1'b0};
    int   m_run[3];
    int   m_evt[3];
    logic m_level[3], m_rise[3], m_fall[3], m_ovf[3];

    task automatic model_reset(input int k);
        m_level[k] = rl[k];
        m_rise[k]  = 1'b0;
        m_fall[k]  = 1'b0;
        m_run[k]   = 0;
        m_evt[k]   = 0;
        m_ovf[k]   = 1'b0;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                model_reset(k);
            end else begin
                m_rise[k] = 1'b0;
                m_fall[k] = 1'b0;
                if (!en[k] || data[k] == m_level[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == fc[k]) begin
                        m_level[k] = ~m_level[k];
                        m_rise[k]  = m_level[k];
                        m_fall[k]  = ~m_level[k];
                        m_run[k]   = 0;
                    end
                end
                if (clr[k]) begin
                    m_evt[k] = 0;
                    m_ovf[k] = 1'b0;
                end
                if (m_rise[k]) begin
                    if (m_evt[k] == emax[k]) m_ovf[k] = 1'b1;
                    else m_evt[k]++;
                end
            end
        end
    end

    function automatic logic [11:0] dut_vec(input int k);
        logic [7:0] e;
        case (k)
            0:       e = evt0;
            1:       e = evt1;
            default: e = {6'b0, evt2};
        endcase
        return {level[k], rise[k], fall[k], ovf[k], e};
    endfunction

    function automatic logic [11:0] mdl_vec(input int k);
        return {m_level[k], m_rise[k], m_fall[k], m_ovf[k], 8'(m_evt[k])};
    endfunction

    // Drives data for n clocks (starting at a negedge) and tallies observed pulses.
    task automatic run_n(input int k, input logic v, input int n, output int rises, output int falls,
                         output int rise_at, output int fall_at, output int mism);
        rises = 0; falls = 0; rise_at = -1; fall_at = -1; mism = 0;
        for (int i = 1; i <= n; i++) begin
            data[k] = v;
            @(negedge clk);
            if (rise[k]) begin rises++; if (rise_at < 0) rise_at = i; end
            if (fall[k]) begin falls++; if (fall_at < 0) fall_at = i; end
            if (rise[k] && fall[k]) mism++;
            if (dut_vec(k) !== mdl_vec(k)) mism++;
        end
    endtask

    int r, f, ra, fa, mm;

    task automatic test_reset();
        rst = 3'b111; data = 3'b000; en = 3'b111; clr = 3'b000;
        for (int k = 0; k < 3; k++) model_reset(k);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (level[k] !== rl[k]) $display("FAIL reset_level[%0d] got %b exp %b", k, level[k], rl[k]); else n_pass++;
            n_checks++; if ({rise[k], fall[k], ovf[k]} !== 3'b000) $display("FAIL reset_pulses[%0d] got %b exp 000", k, {rise[k], fall[k], ovf[k]}); else n_pass++;
        end
        n_checks++; if ({evt0, evt1, evt2} !== 18'd0) $display("FAIL reset_evt got %h exp 0", {evt0, evt1, evt2}); else n_pass++;
        data[1] = 1'b1;
        rst = 3'b000;
    endtask

    task automatic test_basic_rise();
        run_n(0, 1'b1, 20, r, f, ra, fa, mm);
        n_checks++; if (ra !== 16) $display("FAIL basic_rise_at got %0d exp 16", ra); else n_pass++;
        n_checks++; if (r !== 1 || f !== 0) $display("FAIL basic_pulses got r%0d f%0d exp r1 f0", r, f); else n_pass++;
        n_checks++; if (level[0] !== 1'b1 || evt0 !== 8'd1) $display("FAIL basic_state got lvl %b evt %0d exp 1 1", level[0], evt0); else n_pass++;
        n_checks++; if (mm !== 0) $display("FAIL basic_model got %0d mismatches exp 0", mm); else n_pass++;
    endtask

    task automatic test_glitch();
        run_n(0, 1'b0, 20, r, f, ra, fa, mm);
        n_checks++; if (fa !== 16 || f !== 1) $display("FAIL glitch_prep_fall got at %0d n %0d exp 16 1", fa, f); else n_pass++;
        run_n(0, 1'b1, 15, r, f, ra, fa, mm);
        n_checks++; if (r !== 0 || level[0] !== 1'b0) $display("FAIL glitch_15h got r%0d lvl %b exp 0 0", r, level[0]); else n_pass++;
        run_n(0, 1'b0, 1, r, f, ra, fa, mm);
        n_checks++; if (r !== 0 || level[0] !== 1'b0) $display("FAIL glitch_drop got r%0d lvl %b exp 0 0", r, level[0]); else n_pass++;
        run_n(0, 1'b1, 16, r, f, ra, fa, mm);
        n_checks++; if (r !== 1 || ra !== 16) $display("FAIL glitch_rise got n %0d at %0d exp 1 16", r, ra); else n_pass++;
        run_n(0, 1'b0, 15, r, f, ra, fa, mm);
        n_checks++; if (f !== 0 || level[0] !== 1'b1) $display("FAIL glitch_15l got f%0d lvl %b exp 0 1", f, level[0]); else n_pass++;
        run_n(0, 1'b1, 1, r, f, ra, fa, mm);
        run_n(0, 1'b0, 16, r, f, ra, fa, mm);
        n_checks++; if (f !== 1 || fa !== 16 || r !== 0) $display("FAIL glitch_fall got n %0d at %0d r %0d exp 1 16 0", f, fa, r); else n_pass++;
        n_checks++; if (evt0 !== 8'd2) $display("FAIL glitch_evt got %0d exp 2", evt0); else n_pass++;
    endtask

    task automatic test_fc1();
        run_n(1, 1'b1, 2, r, f, ra, fa, mm);
        n_checks++; if (r !== 0 || f !== 0 || level[1] !== 1'b1) $display("FAIL fc1_idle got r%0d f%0d lvl %b exp 0 0 1", r, f, level[1]); else n_pass++;
        run_n(1, 1'b0, 1, r, f, ra, fa, mm);
        n_checks++; if (f !== 1 || fa !== 1 || level[1] !== 1'b0) $display("FAIL fc1_fall got f%0d at %0d lvl %b exp 1 1 0", f, fa, level[1]); else n_pass++;
        run_n(1, 1'b1, 1, r, f, ra, fa, mm);
        n_checks++; if (r !== 1 || f !== 0 || level[1] !== 1'b1) $display("FAIL fc1_rise got r%0d f%0d lvl %b exp 1 0 1", r, f, level[1]); else n_pass++;
        n_checks++; if (evt1 !== 8'd1 || mm !== 0) $display("FAIL fc1_evt got %0d mism %0d exp 1 0", evt1, mm); else n_pass++;
    endtask

    task automatic test_evt_sat();
        int exp_evt[5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            run_n(2, 1'b1, 4, r, f, ra, fa, mm);
            n_checks++; if (r !== 1 || ra !== 3) $display("FAIL evt_rise[%0d] got n %0d at %0d exp 1 3", i, r, ra); else n_pass++;
            n_checks++; if (evt2 !== 2'(exp_evt[i])) $display("FAIL evt_cnt[%0d] got %0d exp %0d", i, evt2, exp_evt[i]); else n_pass++;
            n_checks++; if (ovf[2] !== (i >= 3)) $display("FAIL evt_ovf[%0d] got %b exp %b", i, ovf[2], i >= 3); else n_pass++;
            run_n(2, 1'b0, 4, r, f, ra, fa, mm);
        end
        clr[2] = 1'b1;
        run_n(2, 1'b0, 1, r, f, ra, fa, mm);
        clr[2] = 1'b0;
        n_checks++; if (evt2 !== 2'd0 || ovf[2] !== 1'b0) $display("FAIL evt_clr got %0d ovf %b exp 0 0", evt2, ovf[2]); else n_pass++;
        run_n(2, 1'b1, 4, r, f, ra, fa, mm);
        run_n(2, 1'b0, 4, r, f, ra, fa, mm);
        run_n(2, 1'b1, 2, r, f, ra, fa, mm);
        clr[2] = 1'b1;
        run_n(2, 1'b1, 1, r, f, ra, fa, mm);
        clr[2] = 1'b0;
        n_checks++; if (r !== 1 || evt2 !== 2'd1 || ovf[2] !== 1'b0) $display("FAIL evt_clr_rise got r%0d evt %0d ovf %b exp 1 1 0", r, evt2, ovf[2]); else n_pass++;
    endtask

    task automatic test_enable();
        run_n(0, 1'b1, 10, r, f, ra, fa, mm);
        en[0] = 1'b0;
        run_n(0, 1'b1, 5, r, f, ra, fa, mm);
        n_checks++; if (r !== 0 || level[0] !== 1'b0) $display("FAIL enable_frozen got r%0d lvl %b exp 0 0", r, level[0]); else n_pass++;
        en[0] = 1'b1;
        run_n(0, 1'b1, 20, r, f, ra, fa, mm);
        n_checks++; if (r !== 1 || ra !== 16) $display("FAIL enable_restart got n %0d at %0d exp 1 16", r, ra); else n_pass++;
        n_checks++; if (evt0 !== 8'd3 || mm !== 0) $display("FAIL enable_evt got %0d mism %0d exp 3 0", evt0, mm); else n_pass++;
    endtask

    task automatic test_async_reset();
        run_n(0, 1'b0, 20, r, f, ra, fa, mm);
        run_n(0, 1'b1, 12, r, f, ra, fa, mm);
        #2;
        rst[0] = 1'b1;
        model_reset(0);
        #1;
        n_checks++; if ({level[0], rise[0], fall[0], ovf[0], evt0} !== 12'd0) $display("FAIL async_reset got %h exp 000", {level[0], rise[0], fall[0], ovf[0], evt0}); else n_pass++;
        @(negedge clk);
        rst[0] = 1'b0;
        run_n(0, 1'b1, 20, r, f, ra, fa, mm);
        n_checks++; if (r !== 1 || ra !== 16) $display("FAIL async_rerise got n %0d at %0d exp 1 16", r, ra); else n_pass++;
        n_checks++; if (evt0 !== 8'd1 || mm !== 0) $display("FAIL async_evt got %0d mism %0d exp 1 0", evt0, mm); else n_pass++;
    endtask

    task automatic test_random();
        int tog[3] = '{24, 2, 4};
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, tog[k] - 1) == 0) data[k] = ~data[k];
                en[k]  = ($urandom_range(0, 15) != 0);
                clr[k] = ($urandom_range(0, 31) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (dut_vec(k) !== mdl_vec(k)) $display("FAIL random[%0d] cyc %0d got %h exp %h", k, c, dut_vec(k), mdl_vec(k)); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_glitch();
        test_fc1();
        test_evt_sat();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
